// File: rtl/small_lpf_tdm_sched_pkg.sv
// Shared constants and elaboration helpers for the TDM low-pass filter block.
// Latency: none (compile-time only).
// Backpressure: not applicable.
package small_filt_pkg;

   localparam int DEF_CHANNELS  = 4;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_FILT_BITS = 5;

   // Index width for n items, never narrower than one bit.
   function automatic int f_clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Accumulator width: steady state is x * 2^filt_bits, so this never overflows.
   function automatic int f_acc_w(input int width, input int filt_bits);
      return width + filt_bits;
   endfunction

endpackage

// File: rtl/small_lpf_tdm_sched_if.sv
// Per-channel sample inputs and channel-tagged result output of the TDM filter.
// Latency: none (wiring only).
// Backpressure: per-channel in_ready on the input side; output is a strobe with no ready.
interface small_lpf_tdm_sched_if #(
   parameter int CHANNELS = small_filt_pkg::DEF_CHANNELS,
   parameter int WIDTH    = small_filt_pkg::DEF_WIDTH
);
   import small_filt_pkg::*;

   localparam int CH_BITS = f_clog2(CHANNELS);

   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_ready;
   logic                      out_valid;
   logic [CH_BITS-1:0]        out_chan;
   logic [WIDTH-1:0]          out_data;

   // Source side: offers samples, consumes results.
   modport master (
      output in_valid, in_data,
      input  in_ready, out_valid, out_chan, out_data
   );

   // Filter side.
   modport slave (
      input  in_valid, in_data,
      output in_ready, out_valid, out_chan, out_data
   );

endinterface

// File: rtl/small_lpf_tdm_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or above the pointer, wrapping.
// Latency: grant is combinational from requests; pointer advances on the grant edge.
// Backpressure: en=0 suppresses grants and freezes the pointer.
module rr_arbiter #(
   parameter int CHANNELS = small_filt_pkg::DEF_CHANNELS,
   parameter int CH_BITS  = small_filt_pkg::f_clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_clear,
   input  logic                i_en,
   input  logic [CHANNELS-1:0] i_req,
   output logic                o_gnt_vld,
   output logic [CHANNELS-1:0] o_gnt_oh,
   output logic [CH_BITS-1:0]  o_gnt_idx
);
   import small_filt_pkg::*;

   logic [CH_BITS-1:0]  r_ptr;
   logic                w_found;
   logic [CH_BITS-1:0]  w_idx;
   logic [CH_BITS-1:0]  w_cand;

   // Search from the pointer upward; the first hit wins.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         w_cand = CH_BITS'((int'(r_ptr) + k) % CHANNELS);
         if (!w_found && i_req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
   end

   assign o_gnt_vld = i_en && w_found;
   assign o_gnt_idx = w_idx;
   assign o_gnt_oh  = o_gnt_vld ? (CHANNELS'(1) << w_idx) : '0;

   // Pointer moves one past the winner; idle cycles leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_clear) begin
         r_ptr <= '0;
      end else if (o_gnt_vld) begin
         r_ptr <= CH_BITS'((int'(w_idx) + 1) % CHANNELS);
      end
   end

endmodule

// File: rtl/small_lpf_tdm_sched.sv
// Shares one first-order low-pass (acc += x - acc>>FILT_BITS) across CHANNELS streams.
// Latency: grant at cycle T -> out_valid registered at T+2.
// Backpressure: one-deep holding buffer per channel (in_ready = empty); output never stalls.
module small_lpf_tdm_sched #(
   parameter int CHANNELS  = small_filt_pkg::DEF_CHANNELS,
   parameter int WIDTH     = small_filt_pkg::DEF_WIDTH,
   parameter int FILT_BITS = small_filt_pkg::DEF_FILT_BITS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   clear,
   small_lpf_tdm_sched_if.slave   bus
);
   import small_filt_pkg::*;

   localparam int CH_BITS = f_clog2(CHANNELS);
   localparam int ACC_W   = f_acc_w(WIDTH, FILT_BITS);
   localparam int NXT_W   = ACC_W + 1;

   // Holding buffers
   logic [CHANNELS-1:0] r_hold_vld;
   logic [WIDTH-1:0]    r_hold_dat [CHANNELS];

   // Arbiter results
   logic                w_gnt_vld;
   logic [CHANNELS-1:0] w_gnt_oh;
   logic [CH_BITS-1:0]  w_gnt_idx;

   // Stage 0 (issued sample)
   logic                r_s0_vld;
   logic [CH_BITS-1:0]  r_s0_chan;
   logic [WIDTH-1:0]    r_s0_dat;

   // Per-channel filter state
   logic [ACC_W-1:0]    r_acc [CHANNELS];

   // Stage 1 arithmetic and output register
   logic [ACC_W-1:0]    w_acc_rd;
   logic [NXT_W-1:0]    w_nxt;
   logic                w_unused_carry;
   logic                r_out_vld;
   logic [CH_BITS-1:0]  r_out_chan;
   logic [WIDTH-1:0]    r_out_dat;

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .CH_BITS  (CH_BITS)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (clear),
      .i_en      (en),
      .i_req     (r_hold_vld),
      .o_gnt_vld (w_gnt_vld),
      .o_gnt_oh  (w_gnt_oh),
      .o_gnt_idx (w_gnt_idx)
   );

   // Ready is purely registered so upstream sees no combinational loop through us.
   assign bus.in_ready = ~r_hold_vld;

   // Buffers: a grant frees the slot; a free slot captures an offered sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_vld <= '0;
         for (int i = 0; i < CHANNELS; i++) r_hold_dat[i] <= '0;
      end else if (clear) begin
         r_hold_vld <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt_oh[i]) begin
               r_hold_vld[i] <= 1'b0;
            end else if (bus.in_valid[i] && !r_hold_vld[i]) begin
               r_hold_vld[i] <= 1'b1;
               r_hold_dat[i] <= bus.in_data[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Stage 0: capture the granted sample and its channel tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0_vld  <= 1'b0;
         r_s0_chan <= '0;
         r_s0_dat  <= '0;
      end else if (clear) begin
         r_s0_vld  <= 1'b0;
      end else begin
         r_s0_vld <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_s0_chan <= w_gnt_idx;
            r_s0_dat  <= r_hold_dat[w_gnt_idx];
         end
      end
   end

   // Filter step with one guard bit; the result provably fits back into ACC_W bits.
   assign w_acc_rd       = r_acc[r_s0_chan];
   assign w_nxt          = NXT_W'(w_acc_rd) + NXT_W'(r_s0_dat) - NXT_W'(w_acc_rd >> FILT_BITS);
   assign w_unused_carry = w_nxt[NXT_W-1];

   // Accumulator write-back; a following grant to the same channel reads the new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
      end else if (r_s0_vld) begin
         r_acc[r_s0_chan] <= w_nxt[ACC_W-1:0];
      end
   end

   // Result register: one-cycle strobe, tag and data hold between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld  <= 1'b0;
         r_out_chan <= '0;
         r_out_dat  <= '0;
      end else if (clear) begin
         r_out_vld  <= 1'b0;
      end else begin
         r_out_vld <= r_s0_vld;
         if (r_s0_vld) begin
            r_out_chan <= r_s0_chan;
            r_out_dat  <= w_nxt[FILT_BITS +: WIDTH];
         end
      end
   end

   assign bus.out_valid = r_out_vld;
   assign bus.out_chan  = r_out_chan;
   assign bus.out_data  = r_out_dat;

endmodule

// File: tb/tb_small_lpf_tdm_sched.sv
// Directed bench for small_lpf_tdm_sched with a per-channel sample scoreboard.
// Latency: checks grant+2 result timing.
// Backpressure: exercises holding-buffer ready, en and clear.
module tb_small_lpf_tdm_sched;

   localparam int CH = 4;
   localparam int W  = 8;
   localparam int FB = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic clear;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   small_lpf_tdm_sched_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

   small_lpf_tdm_sched #(.CHANNELS(CH), .WIDTH(W), .FILT_BITS(FB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clear (clear),
      .bus   (bus)
   );

   // ---------------- scoreboard / monitor (negedge) ----------------
   logic [7:0] fq [CH][4];
   int wp [CH]        = '{default: 0};
   int rp [CH]        = '{default: 0};
   int mdl_acc [CH]   = '{default: 0};
   int pulse_cnt [CH] = '{default: 0};
   int last_out [CH]  = '{default: 0};
   int mdl_err   = 0;
   int mono_viol = 0;
   int ord_err   = 0;
   int total     = 0;
   int prev_ch0  = 0;
   int prev_chan = -1;
   int mono_mode = 0;   // 1: ch0 non-decreasing, 2: ch0 non-increasing
   int ord_en    = 0;
   int mc;
   int md;

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            rp[i] = wp[i];
            mdl_acc[i] = 0;
         end
         prev_chan = -1;
      end else begin
         if (bus.out_valid) begin
            mc = int'(bus.out_chan);
            total = total + 1;
            pulse_cnt[mc] = pulse_cnt[mc] + 1;
            if (rp[mc] == wp[mc]) begin
               mdl_err = mdl_err + 1;
            end else begin
               md = int'(fq[mc][rp[mc] % 4]);
               rp[mc] = rp[mc] + 1;
               mdl_acc[mc] = mdl_acc[mc] + md - (mdl_acc[mc] >> FB);
               if (int'(bus.out_data) != (mdl_acc[mc] >> FB)) mdl_err = mdl_err + 1;
            end
            if (mc == 0) begin
               if (mono_mode == 1 && int'(bus.out_data) < prev_ch0) mono_viol = mono_viol + 1;
               if (mono_mode == 2 && int'(bus.out_data) > prev_ch0) mono_viol = mono_viol + 1;
               prev_ch0 = int'(bus.out_data);
            end
            if (ord_en != 0 && prev_chan >= 0 && mc != (prev_chan + 1) % CH) ord_err = ord_err + 1;
            prev_chan = mc;
            last_out[mc] = int'(bus.out_data);
         end
         if (clear) begin
            for (int i = 0; i < CH; i++) begin
               rp[i] = wp[i];
               mdl_acc[i] = 0;
            end
         end else begin
            for (int i = 0; i < CH; i++) begin
               if (bus.in_valid[i] && bus.in_ready[i]) begin
                  fq[i][wp[i] % 4] = bus.in_data[i*W +: W];
                  wp[i] = wp[i] + 1;
               end
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ch(input int c, input logic v, input logic [7:0] d);
      bus.in_valid[c] = v;
      bus.in_data[c*W +: W] = d;
   endtask

   task automatic wait_out(input int max, output logic got);
      got = 1'b0;
      for (int i = 0; i < max && !got; i++) begin
         tick(1);
         if (bus.out_valid) got = 1'b1;
      end
   endtask

   task automatic send_one(input int c, input logic [7:0] d, input int exp, input string tag);
      logic got;
      set_ch(c, 1'b1, d);
      tick(1);
      set_ch(c, 1'b0, 8'd0);
      wait_out(10, got);
      check({tag, " seen"}, got, 1);
      check({tag, " chan"}, bus.out_chan, c);
      check({tag, " data"}, bus.out_data, exp);
      tick(2);
   endtask

   // ---------------- directed sequence ----------------
   int  base [CH];
   int  base_tot;
   int  base_mono;
   int  base_ord;
   int  timeout;
   logic got;

   initial begin
      rst_n = 1'b0;
      en = 1'b1;
      clear = 1'b0;
      bus.in_valid = '0;
      bus.in_data = '0;

      // Reset with garbage on the inputs
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 4'($urandom);
         bus.in_data = 32'($urandom);
         tick(1);
      end
      check("rst in_ready", bus.in_ready, 4'hF);
      check("rst out_valid", bus.out_valid, 0);
      check("rst out_data", bus.out_data, 0);
      check("rst out_chan", bus.out_chan, 0);
      bus.in_valid = '0;
      bus.in_data = '0;
      rst_n = 1'b1;
      tick(2);

      // Single sample on channel 2: 100 -> 3 at grant+2
      set_ch(2, 1'b1, 8'd100);
      tick(1);
      set_ch(2, 1'b0, 8'd0);
      check("single held ready", bus.in_ready, 4'b1011);
      tick(1);
      check("single freed ready", bus.in_ready, 4'hF);
      check("single early valid", bus.out_valid, 0);
      tick(1);
      check("single valid", bus.out_valid, 1);
      check("single chan", bus.out_chan, 2);
      check("single data", bus.out_data, 3);
      tick(1);
      check("single pulse width", bus.out_valid, 0);
      check("single data hold", bus.out_data, 3);
      tick(2);

      // Step response on channel 0
      base_mono = mono_viol;
      mono_mode = 1;
      set_ch(0, 1'b1, 8'd255);
      wait_out(10, got);
      check("step first seen", got, 1);
      check("step first data", bus.out_data, 7);
      base[0] = pulse_cnt[0];
      timeout = 1;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (pulse_cnt[0] - base[0] >= 300) begin
            timeout = 0;
            break;
         end
      end
      check("step timeout", timeout, 0);
      check("step settled", last_out[0], 255);
      tick(4);
      check("step stays", last_out[0], 255);
      check("step monotonic", mono_viol - base_mono, 0);

      // Decay to zero
      base_mono = mono_viol;
      mono_mode = 2;
      set_ch(0, 1'b1, 8'd0);
      base[0] = pulse_cnt[0];
      timeout = 1;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (pulse_cnt[0] - base[0] >= 300) begin
            timeout = 0;
            break;
         end
      end
      check("decay timeout", timeout, 0);
      check("decay final", last_out[0], 0);
      check("decay monotonic", mono_viol - base_mono, 0);
      mono_mode = 0;
      set_ch(0, 1'b0, 8'd0);
      tick(5);
      check("model after step", mdl_err, 0);

      // Fairness with all channels saturated
      for (int c = 0; c < CH; c++) set_ch(c, 1'b1, 8'(20 + 40 * c));
      tick(10);
      for (int c = 0; c < CH; c++) base[c] = pulse_cnt[c];
      base_tot = total;
      base_ord = ord_err;
      ord_en = 1;
      tick(400);
      ord_en = 0;
      check("fair total", total - base_tot, 400);
      check("fair ch0", pulse_cnt[0] - base[0], 100);
      check("fair ch1", pulse_cnt[1] - base[1], 100);
      check("fair ch2", pulse_cnt[2] - base[2], 100);
      check("fair ch3", pulse_cnt[3] - base[3], 100);
      check("fair order", ord_err - base_ord, 0);
      bus.in_valid = '0;
      tick(5);

      // Independence: ch1 at 200, ch3 at 10, from cleared state
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      for (int c = 0; c < CH; c++) base[c] = pulse_cnt[c];
      set_ch(1, 1'b1, 8'd200);
      set_ch(3, 1'b1, 8'd10);
      timeout = 1;
      for (int i = 0; i < 2000; i++) begin
         tick(1);
         if (pulse_cnt[1] - base[1] >= 400 && pulse_cnt[3] - base[3] >= 400) begin
            timeout = 0;
            break;
         end
      end
      bus.in_valid = '0;
      tick(5);
      check("indep timeout", timeout, 0);
      check("indep ch1 range", (last_out[1] >= 199 && last_out[1] <= 200), 1);
      check("indep ch3 range", (last_out[3] >= 9 && last_out[3] <= 10), 1);
      check("indep ch0 idle", pulse_cnt[0] - base[0], 0);
      check("indep ch2 idle", pulse_cnt[2] - base[2], 0);
      send_one(2, 8'd32, 1, "indep ch2 probe");
      check("model after indep", mdl_err, 0);

      // en low with full buffers, then clear
      en = 1'b0;
      for (int c = 0; c < CH; c++) set_ch(c, 1'b1, 8'd50);
      tick(3);
      base_tot = total;
      tick(17);
      check("en0 no output", total - base_tot, 0);
      check("en0 in_ready", bus.in_ready, 4'h0);
      check("en0 out_valid", bus.out_valid, 0);
      clear = 1'b1;
      tick(1);
      check("clear in_ready", bus.in_ready, 4'hF);
      check("clear out_valid", bus.out_valid, 0);
      tick(1);
      check("clear beats load", bus.in_ready, 4'hF);
      clear = 1'b0;
      bus.in_valid = '0;
      en = 1'b1;
      base_tot = total;
      tick(3);
      check("clear no output", total - base_tot, 0);
      send_one(0, 8'd64, 2, "post clear ch0");

      // Async reset in the middle of a busy burst
      for (int c = 0; c < CH; c++) set_ch(c, 1'b1, 8'(100 + c));
      tick(10);
      check("busy before reset", bus.out_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst out_valid", bus.out_valid, 0);
      check("arst out_data", bus.out_data, 0);
      check("arst out_chan", bus.out_chan, 0);
      check("arst in_ready", bus.in_ready, 4'hF);
      bus.in_valid = '0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      base_tot = total;
      tick(6);
      check("arst no stale output", total - base_tot, 0);
      check("arst ready after", bus.in_ready, 4'hF);
      check("model final", mdl_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/small_lpf_tdm_sched.md
Name: small_lpf_tdm_sched

Overview:
Time-division scheduler that shares one unsigned first-order low-pass datapath (acc += x − (acc >> FILT_BITS)) between CHANNELS independent sample streams. Each channel has a one-deep input holding buffer with valid/ready handshake. A round-robin arbiter issues at most one sample per cycle into a 2-stage compute pipeline. The block keeps per-channel accumulator state and emits channel-tagged filtered results. It sits between multi-channel sensor/ADC front-ends and downstream decimators.

Parameters:
CHANNELS, 4, number of requesting streams (2..16)
WIDTH, 8, sample and output width, unsigned
FILT_BITS, 5, filter shift; time constant ≈ 2^FILT_BITS samples
CH_BITS, $clog2(CHANNELS), channel index width (derived, localparam)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  arbitration enable; low = no new grants
clear  in  1  synchronous state clear, active high
in_valid  in  CHANNELS  per-channel sample offered
in_data  in  CHANNELS*WIDTH  packed samples, channel i at [i*WIDTH +: WIDTH]
in_ready  out  CHANNELS  per-channel holding buffer empty
out_valid  out  1  one-cycle result strobe
out_chan  out  CH_BITS  channel of current result
out_data  out  WIDTH  filtered result

Behaviour:
- Reset (rst_n low, async): all accumulators 0, holding buffers empty, in_ready all 1, out_valid 0, out_chan 0, out_data 0, RR pointer = 0, pipeline valids 0.
- Holding buffer i: load when in_valid[i] && in_ready[i]; in_ready[i] = !hold_valid[i] (registered, no combinational in→ready path). Buffer freed on the cycle it is granted; a new sample is accepted at the earliest on the next cycle (max 1 sample / 2 cycles per channel, 1 sample / cycle aggregate).
- Arbiter: when en=1 and any hold_valid, grant the first set hold_valid searching from RR pointer upward with wrap at CHANNELS−1→0. Pointer ← granted+1 (mod CHANNELS). No grant → pointer unchanged. en=0 → no grant; buffers keep data, in-flight stages complete.
- Stage 0 (grant cycle T): latch s0_valid, s0_chan, s0_data.
- Stage 1 (T+1): read acc[s0_chan]; nxt = acc + s0_data − (acc >> FILT_BITS), computed at WIDTH+FILT_BITS+1 bits; write acc[s0_chan] ← nxt (fits in WIDTH+FILT_BITS bits, never saturates). Register out_valid=1, out_chan, out_data = nxt >> FILT_BITS.
- Latency: grant at T → out_valid at T+2. Back-to-back grants to the same channel are hazard-free because the stage-1 read happens after the previous write.
- Output has no backpressure; out_valid is a single-cycle pulse per grant. out_chan/out_data hold their last value when out_valid=0.
- clear=1: next edge zeroes all accumulators, empties all buffers, drops s0_valid and out_valid, resets pointer to 0. clear beats simultaneous in_valid loads and grants.
- Reset mid-operation: in-flight samples are discarded with no output pulse.
- Step response, WIDTH=8, FILT_BITS=5, constant 255 from acc=0: output is monotonic non-decreasing and settles at 255 (acc ∈ [8160,8191]). Constant 0 decays to 0.

Decomposition:
- Package small_filt_pkg: localparams for default WIDTH/FILT_BITS, a clog2 helper, and the acc width function (WIDTH+FILT_BITS).
- Sub-module rr_arbiter (CHANNELS-wide request vector, pointer register, one-hot grant plus index). Accumulator array and pipeline stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with random inputs → in_ready=4'b1111, out_valid=0, out_data=0. Release, apply a single in_valid[2] with 8'd100 → out_valid at grant+2, out_chan=2, out_data=3 (100>>5).
- Step: channel 0 fed constant 255 continuously, other channels idle → out_data monotonic, reaches 255, stays 255. Switch to 0 → out_data decays to 0.
- Fairness: all 4 channels hold in_valid=1 continuously → grants cycle 0,1,2,3,0,…; each channel gets exactly 25% of out_valid pulses over 400 cycles.
- Independence: ch1 constant 200, ch3 constant 10 interleaved → after 400 samples each, ch1 output ∈ [199,200] and ch3 output ∈ [9,10]. ch0 and ch2 accumulators remain 0.
- en/clear: en=0 for 20 cycles with buffers full → no out_valid after pipeline drain, in_ready=0. Pulse clear → in_ready=4'b1111 next cycle, no out_valid; subsequent first sample 64 on ch0 → out_data=2.
- Async reset mid-stream: assert rst_n low between clock edges during a busy burst → outputs 0 immediately, no stale out_valid after release.
